// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and constants for the register master bridge.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } master_state_t;

    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0000;
    localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;

endpackage

// File: rtl/axi4lite_reg_master_if.sv
// Request/response port plus AXI4-Lite master channels of the register master bridge.
interface axi4lite_reg_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [3:0]            req_wstrb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_write;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_resp;

    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [3:0]            AWCACHE;
    logic [2:0]            AWPROT;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [3:0]            WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [3:0]            ARCACHE;
    logic [2:0]            ARPROT;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        input  rsp_ready,
        output AWADDR, AWCACHE, AWPROT, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARCACHE, ARPROT, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RVALID,
        output RREADY
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        output rsp_ready,
        input  AWADDR, AWCACHE, AWPROT, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARCACHE, ARPROT, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RVALID,
        input  RREADY
    );

endinterface

// File: rtl/axi4lite_reg_master.sv
// Single-outstanding AXI4-Lite master: turns one register request into an AXI
// transaction and returns the captured data/response. All AXI outputs are registered.
module axi4lite_reg_master
    import axi_lite_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 32,
    parameter logic [2:0] AXI_PROT   = AXI_PROT_DEFAULT
) (
    input logic                    ACLK,
    input logic                    ARESET,
    axi4lite_reg_master_if.master  bus
);

    master_state_t         r_state,    w_stateNext;
    logic                  r_awValid,  w_awValidNext;
    logic                  r_wValid,   w_wValidNext;
    logic                  r_awDone,   w_awDoneNext;
    logic                  r_wDone,    w_wDoneNext;
    logic                  r_bReady,   w_bReadyNext;
    logic                  r_arValid,  w_arValidNext;
    logic                  r_rReady,   w_rReadyNext;
    logic [ADDR_WIDTH-1:0] r_addr,     w_addrNext;
    logic [DATA_WIDTH-1:0] r_wdata,    w_wdataNext;
    logic [3:0]            r_wstrb,    w_wstrbNext;
    logic                  r_rspValid, w_rspValidNext;
    logic                  r_rspWrite, w_rspWriteNext;
    logic [DATA_WIDTH-1:0] r_rspRdata, w_rspRdataNext;
    axi_resp_t             r_rspResp,  w_rspRespNext;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state    <= IDLE;
            r_awValid  <= 1'b0;
            r_wValid   <= 1'b0;
            r_awDone   <= 1'b0;
            r_wDone    <= 1'b0;
            r_bReady   <= 1'b0;
            r_arValid  <= 1'b0;
            r_rReady   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_rspValid <= 1'b0;
            r_rspWrite <= 1'b0;
            r_rspRdata <= '0;
            r_rspResp  <= OKAY;
        end else begin
            r_state    <= w_stateNext;
            r_awValid  <= w_awValidNext;
            r_wValid   <= w_wValidNext;
            r_awDone   <= w_awDoneNext;
            r_wDone    <= w_wDoneNext;
            r_bReady   <= w_bReadyNext;
            r_arValid  <= w_arValidNext;
            r_rReady   <= w_rReadyNext;
            r_addr     <= w_addrNext;
            r_wdata    <= w_wdataNext;
            r_wstrb    <= w_wstrbNext;
            r_rspValid <= w_rspValidNext;
            r_rspWrite <= w_rspWriteNext;
            r_rspRdata <= w_rspRdataNext;
            r_rspResp  <= w_rspRespNext;
        end
    end

    // AW and W complete independently; BREADY is raised only once both done flags are registered.
    always_comb begin
        w_stateNext    = r_state;
        w_awValidNext  = r_awValid;
        w_wValidNext   = r_wValid;
        w_awDoneNext   = r_awDone;
        w_wDoneNext    = r_wDone;
        w_bReadyNext   = r_bReady;
        w_arValidNext  = r_arValid;
        w_rReadyNext   = r_rReady;
        w_addrNext     = r_addr;
        w_wdataNext    = r_wdata;
        w_wstrbNext    = r_wstrb;
        w_rspValidNext = r_rspValid;
        w_rspWriteNext = r_rspWrite;
        w_rspRdataNext = r_rspRdata;
        w_rspRespNext  = r_rspResp;

        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_addrNext = bus.req_addr;
                    if (bus.req_write) begin
                        w_wdataNext   = bus.req_wdata;
                        w_wstrbNext   = bus.req_wstrb;
                        w_awValidNext = 1'b1;
                        w_wValidNext  = 1'b1;
                        w_awDoneNext  = 1'b0;
                        w_wDoneNext   = 1'b0;
                        w_stateNext   = WR_REQ;
                    end else begin
                        w_arValidNext = 1'b1;
                        w_stateNext   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (r_awValid && bus.AWREADY) begin
                    w_awValidNext = 1'b0;
                    w_awDoneNext  = 1'b1;
                end
                if (r_wValid && bus.WREADY) begin
                    w_wValidNext = 1'b0;
                    w_wDoneNext  = 1'b1;
                end
                if (r_awDone && r_wDone) begin
                    w_bReadyNext = 1'b1;
                    w_stateNext  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bus.BVALID && r_bReady) begin
                    w_rspRespNext  = axi_resp_t'(bus.BRESP);
                    w_bReadyNext   = 1'b0;
                    w_rspWriteNext = 1'b1;
                    w_rspRdataNext = '0;
                    w_rspValidNext = 1'b1;
                    w_stateNext    = RSP;
                end
            end
            RD_REQ: begin
                if (r_arValid && bus.ARREADY) begin
                    w_arValidNext = 1'b0;
                    w_rReadyNext  = 1'b1;
                    w_stateNext   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (bus.RVALID && r_rReady) begin
                    w_rspRdataNext = bus.RDATA;
                    w_rspRespNext  = axi_resp_t'(bus.RRESP);
                    w_rReadyNext   = 1'b0;
                    w_rspWriteNext = 1'b0;
                    w_rspValidNext = 1'b1;
                    w_stateNext    = RSP;
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    w_rspValidNext = 1'b0;
                    w_stateNext    = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign bus.req_ready = (r_state == IDLE) && !ARESET;
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_write = r_rspWrite;
    assign bus.rsp_rdata = r_rspRdata;
    assign bus.rsp_resp  = r_rspResp;

    assign bus.AWADDR  = r_addr;
    assign bus.AWCACHE = AXI_CACHE_DEFAULT;
    assign bus.AWPROT  = AXI_PROT;
    assign bus.AWVALID = r_awValid;
    assign bus.WDATA   = r_wdata;
    assign bus.WSTRB   = r_wstrb;
    assign bus.WVALID  = r_wValid;
    assign bus.BREADY  = r_bReady;
    assign bus.ARADDR  = r_addr;
    assign bus.ARCACHE = AXI_CACHE_DEFAULT;
    assign bus.ARPROT  = AXI_PROT;
    assign bus.ARVALID = r_arValid;
    assign bus.RREADY  = r_rReady;

endmodule

// File: doc/axi4lite_reg_master.md
Name: axi4lite_reg_master

Overview:
- Initiator-side bridge: accepts single register read/write requests on a simple valid/ready request port and issues them as AXI4-Lite master transactions.
- Returns the read data and response code on a valid/ready response port.
- Complements the slave-side AXI4-Lite-to-register bridge.
- Used by on-chip sequencers and CPU shims to drive the config register manager over AXI4-Lite.
- One transaction in flight at a time.

Parameters:
- DATA_WIDTH, 32, AXI data width in bits; must be 32 (WSTRB fixed at 4 bits).
- ADDR_WIDTH, 32, AXI address width in bits.
- AXI_PROT, 3'b000, constant value driven on AWPROT/ARPROT.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_write  out  1  echoes req_write of the completed transaction.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  captured BRESP/RRESP.
- AWADDR, AWCACHE(4), AWPROT(3), AWVALID  out  AXI write address channel.
- AWREADY  in  AXI write address channel ready.
- WDATA, WSTRB(4), WVALID  out  AXI write data channel.
- WREADY  in  AXI write data channel ready.
- BRESP(2), BVALID  in  AXI write response channel.
- BREADY  out  AXI write response channel ready.
- ARADDR, ARCACHE(4), ARPROT(3), ARVALID  out  AXI read address channel.
- ARREADY  in  AXI read address channel ready.
- RDATA, RRESP(2), RVALID  in  AXI read data channel.
- RREADY  out  AXI read data channel ready.

Behaviour:
- Reset (ARESET=1 at a clock edge):
  - state=IDLE.
  - All VALID/READY outputs 0, including req_ready and rsp_valid.
  - Address, data, strobe and rsp_* registers cleared to 0.
- Reset takes effect from any state, including mid-transaction; the in-flight transaction is dropped and no response is produced.
- AWCACHE/ARCACHE are tied to 4'b0000; AWPROT/ARPROT are tied to AXI_PROT.
- All AXI outputs are registered. No combinational path from any AXI input to any AXI output.
- req_ready = (state==IDLE) && !ARESET.
- State machine:
  - IDLE:
    - Write request accepted: latch addr/wdata/wstrb; next cycle AWVALID=1 and WVALID=1; go to WR_REQ.
    - Read request accepted: latch addr; next cycle ARVALID=1; go to RD_REQ.
  - WR_REQ:
    - AW and W are tracked independently with flags aw_done/w_done.
    - AWVALID drops the cycle after AWREADY is sampled high; WVALID drops the cycle after WREADY is sampled high.
    - Either channel may complete first, or both in the same cycle.
    - VALID is never withdrawn before its handshake, and address/data are stable while VALID=1.
    - When both channels are done: BREADY=1, go to WR_RESP.
  - WR_RESP:
    - On BVALID && BREADY: capture BRESP, BREADY=0, rsp_write=1, rsp_rdata=0, rsp_valid=1; go to RSP.
  - RD_REQ:
    - On ARREADY: ARVALID=0, RREADY=1; go to RD_RESP.
  - RD_RESP:
    - On RVALID && RREADY: capture RDATA/RRESP, RREADY=0, rsp_write=0, rsp_valid=1; go to RSP.
  - RSP:
    - rsp_* are held stable until rsp_ready.
    - On handshake: rsp_valid=0; go to IDLE. req_ready rises the following cycle.
- BREADY and RREADY are asserted only in their response states.
  - A BVALID or RVALID arriving earlier is left pending; the slave must hold it.
- Minimum latency, zero-wait slave with rsp_ready=1:
  - Write: 4 cycles from request accept to rsp_valid.
  - Read: 3 cycles from request accept to rsp_valid.
- SLVERR/DECERR responses are reported unchanged in rsp_resp. No retry, no error state.

Decomposition:
- Package axi_lite_pkg:
  - axi_resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - master_state_t enum: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
  - Constants AXI_CACHE_DEFAULT=4'b0000 and AXI_PROT_DEFAULT=3'b000.
- Single module; no sub-module needed.

Test Plan:
- Write 0x0000_0010 / 0xDEAD_BEEF / strb 4'hF; AWREADY 2 cycles before WREADY -> AWVALID drops first, WVALID held until WREADY; one B handshake; rsp_valid with rsp_resp=00, rsp_write=1, rsp_rdata=0.
- Write with WREADY 3 cycles before AWREADY, then a second write with AWREADY and WREADY in the same cycle -> both complete; exactly one AW, one W and one B handshake per request; AWADDR/WDATA stable throughout VALID.
- Read 0x0000_0020; slave returns RDATA=0x1234_5678, RRESP=2'b10 after 5 wait cycles -> rsp_rdata=0x1234_5678, rsp_resp=2'b10, rsp_write=0.
- rsp_ready held low 10 cycles after rsp_valid -> rsp_* stable; req_ready=0; no new AXI activity; on release, req_ready=1 the next cycle.
- Slave holds BVALID high from the cycle AW completes -> BREADY rises only after both AW and W have completed; a single B handshake occurs.
- ARESET pulsed while ARVALID=1 (RD_REQ) -> next cycle all VALID/READY=0, rsp_valid=0, state IDLE; a following read completes normally.
